// File: rtl/pid_seq_pkg.sv
// Shared constants for the PID sequencer: FSM state encoding and bus register selects.
package pid_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_STORE = 3'd4;

    localparam logic [1:0] REG_SP     = 2'd0;
    localparam logic [1:0] REG_COEF   = 2'd1;
    localparam logic [1:0] REG_COMMIT = 2'd2;
    localparam logic [1:0] REG_CLR    = 2'd3;

endpackage

// File: rtl/pid_err_sat.sv
// Combinational loop error: setpoint minus position, one bit wider, clamped back to EW bits.
module pid_err_sat #(
    parameter int EW = 24
) (
    input  logic signed [EW-1:0] sp_i,
    input  logic signed [EW-1:0] pos_i,
    output logic signed [EW-1:0] err_o
);

    function automatic logic signed [EW-1:0] sat_ew(input logic signed [EW:0] v);
        if (v[EW] != v[EW-1])
            return v[EW] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
        return v[EW-1:0];
    endfunction

    logic signed [EW:0] diff;

    assign diff  = {sp_i[EW-1], sp_i} - {pos_i[EW-1], pos_i};
    assign err_o = sat_ew(diff);

endmodule

// File: rtl/pid_sequencer.sv
// Round-robin scheduler in front of the shared PID core: one pass over all channels per tick,
// with shadow/active setpoint and gain banks swapped only at frame start.
module pid_sequencer
    import pid_seq_pkg::*;
#(
    parameter int AW = 1,
    parameter int EW = 24,
    parameter int OW = 12,
    parameter int CW = 6,
    parameter int TW = 10
) (
    input  logic                      clk_pid,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [(2**AW)*EW-1:0]     position,
    input  logic                      bus_wr,
    input  logic [AW+1:0]             bus_addr,
    input  logic [31:0]               bus_wdata,
    output logic                      pid_start,
    output logic [AW-1:0]             pid_addr,
    output logic signed [EW-1:0]      pid_error,
    output logic signed [CW-1:0]      pid_kp,
    output logic signed [CW-1:0]      pid_ki,
    output logic signed [CW-1:0]      pid_kd,
    input  logic                      pid_done,
    input  logic signed [OW-1:0]      pid_out,
    output logic [(2**AW)*OW-1:0]     m_out,
    output logic [(2**AW)-1:0]        m_valid,
    output logic                      busy,
    output logic                      overrun,
    output logic [(2**AW)-1:0]        fault
);

    localparam int NCH = 2**AW;
    // Last WAIT count before giving up: the core gets 2^TW-1 cycles in total.
    localparam logic [TW-1:0] TMO_LAST = TW'((2**TW) - 2);

    logic [2:0]             state_q, state_d;
    logic [AW-1:0]          ch_q, ch_d;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   overrun_q, overrun_d;
    logic [NCH-1:0]         fault_q, fault_d;
    logic [NCH-1:0]         m_valid_q, m_valid_d;
    logic                   apply_c, capture_c, timeout_c;

    logic signed [EW-1:0]   sp_sh_q  [NCH];
    logic signed [EW-1:0]   sp_act_q [NCH];
    logic signed [CW-1:0]   kp_sh_q  [NCH];
    logic signed [CW-1:0]   ki_sh_q  [NCH];
    logic signed [CW-1:0]   kd_sh_q  [NCH];
    logic signed [CW-1:0]   kp_act_q [NCH];
    logic signed [CW-1:0]   ki_act_q [NCH];
    logic signed [CW-1:0]   kd_act_q [NCH];
    logic signed [OW-1:0]   m_out_q  [NCH];
    logic signed [EW-1:0]   pos_arr  [NCH];
    logic signed [EW-1:0]   err_sat;

    logic [AW-1:0]          bus_ch;
    logic                   wr_sp, wr_coef, wr_commit, wr_clr;
    logic                   unused_wdata;

    assign bus_ch       = bus_addr[AW-1:0];
    assign wr_sp        = bus_wr && (bus_addr[AW+1:AW] == REG_SP);
    assign wr_coef      = bus_wr && (bus_addr[AW+1:AW] == REG_COEF);
    assign wr_commit    = bus_wr && (bus_addr[AW+1:AW] == REG_COMMIT);
    assign wr_clr       = bus_wr && (bus_addr[AW+1:AW] == REG_CLR);
    assign unused_wdata = ^bus_wdata;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pos_arr[i]         = position[i*EW +: EW];
            m_out[i*OW +: OW]  = m_out_q[i];
        end
    end

    pid_err_sat #(.EW(EW)) u_err_sat (
        .sp_i  (sp_act_q[ch_q]),
        .pos_i (pos_arr[ch_q]),
        .err_o (err_sat)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        overrun_d = overrun_q;
        fault_d   = fault_q;
        m_valid_d = '0;
        apply_c   = 1'b0;
        capture_c = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_LOAD;
                    ch_d    = '0;
                    if (pend_q) begin
                        apply_c = 1'b1;
                        pend_d  = 1'b0;
                    end
                end
            end
            ST_LOAD:  state_d = ST_START;
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pid_done) begin
                    capture_c = 1'b1;
                    state_d   = ST_STORE;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = ST_STORE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_STORE: begin
                if (&ch_q) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + AW'(1);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A commit landing on the frame-start cycle must survive the clear above.
        if (wr_commit) pend_d = 1'b1;
        if (wr_clr) begin
            overrun_d = 1'b0;
            fault_d   = '0;
        end
        if (tick && (state_q != ST_IDLE)) overrun_d = 1'b1;
        if (timeout_c) fault_d[ch_q] = 1'b1;
        if (capture_c) m_valid_d[ch_q] = 1'b1;
    end

    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            fault_q   <= '0;
            m_valid_q <= '0;
            pid_addr  <= '0;
            pid_error <= '0;
            pid_kp    <= '0;
            pid_ki    <= '0;
            pid_kd    <= '0;
            for (int i = 0; i < NCH; i++) begin
                sp_sh_q[i]  <= '0;
                sp_act_q[i] <= '0;
                kp_sh_q[i]  <= '0;
                ki_sh_q[i]  <= '0;
                kd_sh_q[i]  <= '0;
                kp_act_q[i] <= '0;
                ki_act_q[i] <= '0;
                kd_act_q[i] <= '0;
                m_out_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            fault_q   <= fault_d;
            m_valid_q <= m_valid_d;
            if (wr_sp) sp_sh_q[bus_ch] <= bus_wdata[EW-1:0];
            if (wr_coef) begin
                kp_sh_q[bus_ch] <= bus_wdata[CW-1:0];
                ki_sh_q[bus_ch] <= bus_wdata[2*CW-1:CW];
                kd_sh_q[bus_ch] <= bus_wdata[3*CW-1:2*CW];
            end
            if (apply_c) begin
                sp_act_q <= sp_sh_q;
                kp_act_q <= kp_sh_q;
                ki_act_q <= ki_sh_q;
                kd_act_q <= kd_sh_q;
            end
            if (state_q == ST_LOAD) begin
                pid_error <= err_sat;
                pid_addr  <= ch_q;
                pid_kp    <= kp_act_q[ch_q];
                pid_ki    <= ki_act_q[ch_q];
                pid_kd    <= kd_act_q[ch_q];
            end
            if (capture_c) m_out_q[ch_q] <= pid_out;
        end
    end

    assign pid_start = (state_q == ST_START);
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;
    assign fault     = fault_q;
    assign m_valid   = m_valid_q;

endmodule

// File: tb/tb_pid_sequencer.sv
// Bench for pid_sequencer: emulated PID core plus a register-level model of the scheduler.
module tb_pid_sequencer;

    localparam int AW  = 1;
    localparam int NCH = 2;
    localparam int EW  = 24;
    localparam int OW  = 12;
    localparam int CW  = 6;
    localparam int TW  = 10;

    logic                   clk_pid = 1'b0;
    logic                   reset, tick, bus_wr, pid_start, pid_done, busy, overrun;
    logic [AW+1:0]          bus_addr;
    logic [31:0]            bus_wdata;
    logic [NCH*EW-1:0]      position;
    logic [AW-1:0]          pid_addr;
    logic signed [EW-1:0]   pid_error;
    logic signed [CW-1:0]   pid_kp, pid_ki, pid_kd;
    logic signed [OW-1:0]   pid_out;
    logic [NCH*OW-1:0]      m_out;
    logic [NCH-1:0]         m_valid, fault;

    pid_sequencer #(.AW(AW), .EW(EW), .OW(OW), .CW(CW), .TW(TW)) dut (
        .clk_pid(clk_pid), .reset(reset), .tick(tick), .position(position),
        .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .pid_start(pid_start), .pid_addr(pid_addr), .pid_error(pid_error),
        .pid_kp(pid_kp), .pid_ki(pid_ki), .pid_kd(pid_kd),
        .pid_done(pid_done), .pid_out(pid_out),
        .m_out(m_out), .m_valid(m_valid), .busy(busy), .overrun(overrun), .fault(fault)
    );

    always #5 clk_pid = ~clk_pid;

    int n_checks = 0;
    int n_fail   = 0;

    // core emulation controls and observations
    int lat[NCH], resp_val[NCH];
    bit no_resp[NCH];
    int cap_err[NCH], cap_kp[NCH], cap_ki[NCH], cap_kd[NCH], st_tot[NCH], mv_tot[NCH];
    int busy_tot, stray_req, stray_served, stray_val;

    // reference model
    longint m_sp_sh[NCH], m_sp_act[NCH], m_pos[NCH], exp_err[NCH];
    int     m_kp_sh[NCH], m_ki_sh[NCH], m_kd_sh[NCH];
    int     m_kp_act[NCH], m_ki_act[NCH], m_kd_act[NCH], exp_mout[NCH];
    bit     m_pend, m_busy, m_overrun;
    bit [NCH-1:0] m_fault;
    int     exp_cycles;

    // snapshots
    int b0, mv0[NCH], st0[NCH];
    bit to;

    function automatic longint sx(input longint v, input int w);
        longint r;
        r = v & ((64'sd1 <<< w) - 1);
        if (r >= (64'sd1 <<< (w - 1))) r = r - (64'sd1 <<< w);
        return r;
    endfunction

    function automatic longint clampe(input longint v);
        longint hi, lo;
        hi = (64'sd1 <<< (EW - 1)) - 1;
        lo = -(64'sd1 <<< (EW - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int mout_of(input int c);
        return int'($signed(m_out[c*OW +: OW]));
    endfunction

    initial begin : core_emul
        int done_cd, cur_ch;
        done_cd = 0; cur_ch = 0; stray_served = 0;
        pid_done = 1'b0; pid_out = '0;
        for (int i = 0; i < NCH; i++) st_tot[i] = 0;
        forever begin
            @(negedge clk_pid);
            pid_done = 1'b0;
            if (reset) done_cd = 0;
            else if (done_cd == 1) begin
                pid_done = 1'b1; pid_out = OW'(resp_val[cur_ch]); done_cd = 0;
            end else if (done_cd > 1) done_cd--;
            if (stray_req != stray_served) begin
                pid_done = 1'b1; pid_out = OW'(stray_val); stray_served++;
            end
            if (pid_start === 1'b1 && !reset) begin
                cur_ch = int'(pid_addr);
                cap_err[cur_ch] = int'(pid_error);
                cap_kp[cur_ch]  = int'(pid_kp);
                cap_ki[cur_ch]  = int'(pid_ki);
                cap_kd[cur_ch]  = int'(pid_kd);
                st_tot[cur_ch]++;
                if (!no_resp[cur_ch]) done_cd = lat[cur_ch];
            end
        end
    end

    initial begin : monitor
        busy_tot = 0;
        for (int i = 0; i < NCH; i++) mv_tot[i] = 0;
        forever begin
            @(negedge clk_pid);
            if (busy === 1'b1) busy_tot++;
            for (int i = 0; i < NCH; i++) if (m_valid[i] === 1'b1) mv_tot[i]++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_sp_sh[i] = 0; m_sp_act[i] = 0;
            m_kp_sh[i] = 0; m_ki_sh[i] = 0; m_kd_sh[i] = 0;
            m_kp_act[i] = 0; m_ki_act[i] = 0; m_kd_act[i] = 0;
            exp_mout[i] = 0;
        end
        m_pend = 0; m_busy = 0; m_overrun = 0; m_fault = '0;
    endtask

    task automatic bus_cycle(input bit t, input bit wr, input int r, input int ch, input logic [31:0] d);
        tick = t; bus_wr = wr; bus_addr = {r[1:0], ch[AW-1:0]}; bus_wdata = d;
        if (wr && r == 3) begin m_overrun = 0; m_fault = '0; end
        if (t) begin
            if (m_busy) m_overrun = 1;
            else begin
                if (m_pend) begin
                    m_sp_act = m_sp_sh; m_kp_act = m_kp_sh; m_ki_act = m_ki_sh; m_kd_act = m_kd_sh;
                    m_pend = 0;
                end
                m_busy = 1;
            end
        end
        if (wr) begin
            case (r)
                0: m_sp_sh[ch] = sx(longint'(d), EW);
                1: begin
                    m_kp_sh[ch] = int'(sx(longint'(d), CW));
                    m_ki_sh[ch] = int'(sx(longint'(d >> CW), CW));
                    m_kd_sh[ch] = int'(sx(longint'(d >> (2*CW)), CW));
                end
                2: m_pend = 1;
                default: ;
            endcase
        end
        @(negedge clk_pid);
        tick = 1'b0; bus_wr = 1'b0;
    endtask

    task automatic set_pos(input int ch, input longint p);
        position[ch*EW +: EW] = EW'(p);
        m_pos[ch] = sx(p, EW);
    endtask

    task automatic snap();
        b0 = busy_tot;
        for (int i = 0; i < NCH; i++) begin mv0[i] = mv_tot[i]; st0[i] = st_tot[i]; end
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin @(negedge clk_pid); n++; end
        to = (n >= 5000);
        m_busy = 0; exp_cycles = 0;
        for (int c = 0; c < NCH; c++) begin
            exp_err[c] = clampe(m_sp_act[c] - m_pos[c]);
            exp_cycles += 3 + (no_resp[c] ? 1023 : lat[c]);
            if (no_resp[c]) m_fault[c] = 1;
            else exp_mout[c] = resp_val[c];
        end
    endtask

    task automatic test_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (pid_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b required 0", pid_start); end
        n_checks++; if (overrun !== 1'b0 || fault !== '0) begin n_fail++; $display("FAIL reset_flags: got %b/%b required 0/00", overrun, fault); end
        n_checks++; if (m_out !== '0 || m_valid !== '0) begin n_fail++; $display("FAIL reset_mout: got %h/%b required 0/00", m_out, m_valid); end
        n_checks++; if (pid_error !== '0 || pid_addr !== '0 || pid_kp !== '0) begin n_fail++; $display("FAIL reset_core_if: got %0d/%0d/%0d required 0", pid_error, pid_addr, pid_kp); end
    endtask

    task automatic test_basic();
        lat[0] = 3; lat[1] = 3; resp_val[0] = 5; resp_val[1] = int'($urandom_range(0, 4095)) - 2048;
        bus_cycle(0, 1, 0, 0, 32'd100); set_pos(0, 40);
        bus_cycle(0, 1, 0, 1, $urandom_range(0, 2000000)); set_pos(1, longint'($urandom_range(0, 2000000)) - 1000000);
        bus_cycle(0, 1, 1, 0, $urandom); bus_cycle(0, 1, 1, 1, $urandom);
        bus_cycle(0, 1, 2, 0, 0);
        snap(); bus_cycle(1, 0, 0, 0, 0); finish_frame();
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_done: got busy stuck required frame end"); end
        n_checks++; if (cap_err[0] !== 60) begin n_fail++; $display("FAIL basic_err0: got %0d required 60", cap_err[0]); end
        n_checks++; if (mout_of(0) !== 5) begin n_fail++; $display("FAIL basic_mout0: got %0d required 5", mout_of(0)); end
        n_checks++; if (exp_cycles !== busy_tot - b0) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", busy_tot - b0, exp_cycles); end
        for (int c = 0; c < NCH; c++) begin
            n_checks++; if (longint'(cap_err[c]) !== exp_err[c]) begin n_fail++; $display("FAIL basic_err ch%0d: got %0d required %0d", c, cap_err[c], exp_err[c]); end
            n_checks++; if (cap_kp[c] !== m_kp_act[c] || cap_ki[c] !== m_ki_act[c] || cap_kd[c] !== m_kd_act[c]) begin
                n_fail++; $display("FAIL basic_gains ch%0d: got %0d/%0d/%0d required %0d/%0d/%0d", c, cap_kp[c], cap_ki[c], cap_kd[c], m_kp_act[c], m_ki_act[c], m_kd_act[c]); end
            n_checks++; if (mout_of(c) !== exp_mout[c]) begin n_fail++; $display("FAIL basic_mout ch%0d: got %0d required %0d", c, mout_of(c), exp_mout[c]); end
            n_checks++; if (mv_tot[c] - mv0[c] !== 1) begin n_fail++; $display("FAIL basic_mvalid ch%0d: got %0d pulses required 1", c, mv_tot[c] - mv0[c]); end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] spd[4];
        longint ps[4];
        spd = '{32'h007F_FFFF, 32'h0080_0000, 32'h007F_FFFF, 32'h00FF_FFFF};
        ps  = '{-(64'sd1 <<< 23), (64'sd1 <<< 23) - 1, 0, (64'sd1 <<< 23) - 1};
        for (int k = 0; k < 2; k++) begin
            bus_cycle(0, 1, 0, 0, spd[2*k]);   set_pos(0, ps[2*k]);
            bus_cycle(0, 1, 0, 1, spd[2*k+1]); set_pos(1, ps[2*k+1]);
            bus_cycle(0, 1, 2, 0, 0);
            bus_cycle(1, 0, 0, 0, 0); finish_frame();
            for (int c = 0; c < NCH; c++) begin
                n_checks++; if (longint'(cap_err[c]) !== exp_err[c]) begin n_fail++; $display("FAIL sat_err k%0d ch%0d: got %0d required %0d", k, c, cap_err[c], exp_err[c]); end
            end
        end
        n_checks++; if (cap_err[1] !== -8388608) begin n_fail++; $display("FAIL sat_neg_edge: got %0d required -8388608", cap_err[1]); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) == 1) bus_cycle(0, 1, 0, c, $urandom);
                if ($urandom_range(0, 1) == 1) bus_cycle(0, 1, 1, c, $urandom);
                set_pos(c, sx(longint'($urandom), EW));
                lat[c] = $urandom_range(1, 6);
                resp_val[c] = int'($urandom_range(0, 4095)) - 2048;
            end
            if ($urandom_range(0, 2) != 0) bus_cycle(0, 1, 2, 0, 0);
            snap(); bus_cycle(1, 0, 0, 0, 0); finish_frame();
            n_checks++; if (exp_cycles !== busy_tot - b0) begin n_fail++; $display("FAIL rand_latency f%0d: got %0d required %0d", f, busy_tot - b0, exp_cycles); end
            for (int c = 0; c < NCH; c++) begin
                n_checks++; if (longint'(cap_err[c]) !== exp_err[c]) begin n_fail++; $display("FAIL rand_err f%0d ch%0d: got %0d required %0d", f, c, cap_err[c], exp_err[c]); end
                n_checks++; if (cap_kp[c] !== m_kp_act[c] || cap_ki[c] !== m_ki_act[c] || cap_kd[c] !== m_kd_act[c]) begin
                    n_fail++; $display("FAIL rand_gains f%0d ch%0d: got %0d/%0d/%0d required %0d/%0d/%0d", f, c, cap_kp[c], cap_ki[c], cap_kd[c], m_kp_act[c], m_ki_act[c], m_kd_act[c]); end
                n_checks++; if (mout_of(c) !== exp_mout[c] || mv_tot[c] - mv0[c] !== 1) begin
                    n_fail++; $display("FAIL rand_mout f%0d ch%0d: got %0d (%0d pulses) required %0d (1 pulse)", f, c, mout_of(c), mv_tot[c] - mv0[c], exp_mout[c]); end
            end
        end
    endtask

    task automatic test_shadow();
        lat[0] = 2; lat[1] = 2;
        bus_cycle(0, 1, 1, 1, 32'd5); bus_cycle(0, 1, 2, 0, 0);
        bus_cycle(1, 0, 0, 0, 0); finish_frame();
        bus_cycle(1, 0, 0, 0, 0);
        bus_cycle(0, 1, 1, 1, 32'd3);
        finish_frame();
        n_checks++; if (cap_kp[1] !== m_kp_act[1] || cap_kp[1] !== 5) begin n_fail++; $display("FAIL shadow_midframe: got kp %0d required 5", cap_kp[1]); end
        bus_cycle(1, 0, 0, 0, 0); finish_frame();
        n_checks++; if (cap_kp[1] !== 5) begin n_fail++; $display("FAIL shadow_nocommit: got kp %0d required 5", cap_kp[1]); end
        bus_cycle(0, 1, 2, 0, 0); bus_cycle(1, 0, 0, 0, 0); finish_frame();
        n_checks++; if (cap_kp[1] !== 3 || cap_kp[1] !== m_kp_act[1]) begin n_fail++; $display("FAIL shadow_commit: got kp %0d required 3", cap_kp[1]); end
    endtask

    task automatic test_commit_same_cycle();
        set_pos(0, 0);
        bus_cycle(0, 1, 0, 0, 32'd1000);
        bus_cycle(1, 1, 2, 0, 0); finish_frame();
        n_checks++; if (longint'(cap_err[0]) !== exp_err[0] || cap_err[0] === 1000) begin n_fail++; $display("FAIL commit_tick_same: got %0d required %0d", cap_err[0], exp_err[0]); end
        bus_cycle(1, 0, 0, 0, 0); finish_frame();
        n_checks++; if (cap_err[0] !== 1000) begin n_fail++; $display("FAIL commit_next_frame: got %0d required 1000", cap_err[0]); end
    endtask

    task automatic test_timeout();
        lat[0] = 2; no_resp[1] = 1; resp_val[0] = int'($urandom_range(0, 2047));
        snap(); bus_cycle(1, 0, 0, 0, 0); finish_frame();
        n_checks++; if (fault !== 2'b10 || fault !== m_fault) begin n_fail++; $display("FAIL timeout_fault: got %b required 10", fault); end
        n_checks++; if (mout_of(1) !== exp_mout[1] || mv_tot[1] - mv0[1] !== 0) begin n_fail++; $display("FAIL timeout_keep: got %0d (%0d pulses) required %0d (0 pulses)", mout_of(1), mv_tot[1] - mv0[1], exp_mout[1]); end
        n_checks++; if (mout_of(0) !== exp_mout[0] || mv_tot[0] - mv0[0] !== 1) begin n_fail++; $display("FAIL timeout_ch0: got %0d required %0d", mout_of(0), exp_mout[0]); end
        n_checks++; if (busy_tot - b0 !== exp_cycles) begin n_fail++; $display("FAIL timeout_len: got %0d required %0d", busy_tot - b0, exp_cycles); end
        no_resp[1] = 0;
        bus_cycle(0, 1, 3, 0, 0);
        n_checks++; if (fault !== '0) begin n_fail++; $display("FAIL timeout_clear: got %b required 00", fault); end
    endtask

    task automatic test_overrun();
        lat[0] = 10; lat[1] = 10;
        snap(); bus_cycle(1, 0, 0, 0, 0);
        repeat (4) @(negedge clk_pid);
        bus_cycle(1, 1, 3, 0, 0);
        finish_frame();
        repeat (5) @(negedge clk_pid);
        n_checks++; if (overrun !== 1'b1 || overrun !== m_overrun) begin n_fail++; $display("FAIL overrun_set: got %b required 1", overrun); end
        n_checks++; if (busy !== 1'b0 || mv_tot[0] - mv0[0] !== 1 || st_tot[1] - st0[1] !== 1) begin
            n_fail++; $display("FAIL overrun_once: got busy %b, %0d pulses, %0d starts required 0, 1, 1", busy, mv_tot[0] - mv0[0], st_tot[1] - st0[1]); end
        bus_cycle(0, 1, 3, 0, 0);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b required 0", overrun); end
    endtask

    task automatic test_stray_done();
        snap();
        stray_val = int'($urandom_range(0, 4095)) - 2048;
        stray_req++;
        repeat (3) @(negedge clk_pid);
        for (int c = 0; c < NCH; c++) begin
            n_checks++; if (mout_of(c) !== exp_mout[c] || mv_tot[c] !== mv0[c]) begin n_fail++; $display("FAIL stray_done ch%0d: got %0d required %0d", c, mout_of(c), exp_mout[c]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        lat[0] = 40; lat[1] = 40;
        snap(); bus_cycle(1, 0, 0, 0, 0);
        n = 0;
        while (st_tot[0] == st0[0] && n < 20) begin @(negedge clk_pid); n++; end
        repeat (5) @(negedge clk_pid);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || m_out !== '0 || pid_start !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got busy %b m_out %h required 0/0", busy, m_out); end
        repeat (3) @(negedge clk_pid);
        n_checks++; if (pid_start !== 1'b0 || st_tot[1] !== st0[1] || mv_tot[0] !== mv0[0]) begin n_fail++; $display("FAIL midreset_quiet: got %0d starts %0d pulses required 0/0", st_tot[1] - st0[1], mv_tot[0] - mv0[0]); end
        reset = 1'b0;
        model_reset();
        lat[0] = 2; lat[1] = 2;
        resp_val[0] = int'($urandom_range(0, 4095)) - 2048; resp_val[1] = int'($urandom_range(0, 4095)) - 2048;
        bus_cycle(0, 1, 0, 1, $urandom);
        bus_cycle(0, 1, 2, 0, 0);
        snap(); bus_cycle(1, 0, 0, 0, 0); finish_frame();
        for (int c = 0; c < NCH; c++) begin
            n_checks++; if (mout_of(c) !== exp_mout[c] || mv_tot[c] - mv0[c] !== 1 || longint'(cap_err[c]) !== exp_err[c]) begin
                n_fail++; $display("FAIL midreset_frame ch%0d: got %0d err %0d required %0d err %0d", c, mout_of(c), cap_err[c], exp_mout[c], exp_err[c]); end
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0; position = '0;
        stray_req = 0; stray_val = 0;
        for (int i = 0; i < NCH; i++) begin lat[i] = 1; resp_val[i] = 0; no_resp[i] = 0; m_pos[i] = 0; end
        model_reset();
        repeat (3) @(negedge clk_pid);
        test_reset();
        reset = 1'b0;
        @(negedge clk_pid);
        test_basic();
        test_saturation();
        test_random();
        test_shadow();
        test_commit_same_cycle();
        test_timeout();
        test_overrun();
        test_stray_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
